axis_spectrum_power: RTL

AXIS_SPECTRUM_POWER -- requirements
Module: axis_spectrum_power

---
 rtl/vibrometer_axis_pkg.sv | 14 +
 rtl/complex_mag_sq.sv | 64 ++++++
 rtl/axis_spectrum_power.sv | 95 +++++++++
 3 files changed

// File: rtl/vibrometer_axis_pkg.sv
// Shared widths and sample layout for the vibrometer AXI-Stream spectrum chain.
package vibrometer_axis_pkg;

   localparam int AXIS_TDATA_WIDTH_DEF = 32;
   localparam int POWER_WIDTH_DEF      = 32;
   localparam int BIN_WIDTH_DEF        = 16;

   // Complex bin as it appears on tdata: imag in the upper half, real in the lower.
   typedef struct packed {
      logic signed [15:0] im;
      logic signed [15:0] re;
   } cplx_sample_t;

endpackage

// File: rtl/complex_mag_sq.sv
// Three-stage |z|^2 datapath: input register, squaring, unsigned sum.
module complex_mag_sq
   import vibrometer_axis_pkg::*;
#(
   parameter int DATA_WIDTH  = AXIS_TDATA_WIDTH_DEF,
   parameter int POWER_WIDTH = POWER_WIDTH_DEF
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   ce,
   input  logic                   in_valid,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic                   in_last,
   output logic                   out_valid,
   output logic [POWER_WIDTH-1:0] out_power,
   output logic                   out_last
);

   localparam int HALF = DATA_WIDTH / 2;

   logic                         s1_valid;
   logic                         s1_last;
   logic signed [HALF-1:0]       s1_re;
   logic signed [HALF-1:0]       s1_im;
   logic                         s2_valid;
   logic                         s2_last;
   logic signed [DATA_WIDTH-1:0] s2_re_sq;
   logic signed [DATA_WIDTH-1:0] s2_im_sq;
   logic signed [DATA_WIDTH-1:0] re_ext;
   logic signed [DATA_WIDTH-1:0] im_ext;

   // Squares of a signed half-width value always fit the full width as non-negative numbers.
   assign re_ext = DATA_WIDTH'(s1_re);
   assign im_ext = DATA_WIDTH'(s1_im);

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         s1_re     <= '0;
         s1_im     <= '0;
         s2_valid  <= 1'b0;
         s2_last   <= 1'b0;
         s2_re_sq  <= '0;
         s2_im_sq  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_power <= '0;
      end else if (ce) begin
         s1_valid  <= in_valid;
         s1_last   <= in_last & in_valid;
         s1_re     <= in_data[HALF-1:0];
         s1_im     <= in_data[DATA_WIDTH-1:HALF];
         s2_valid  <= s1_valid;
         s2_last   <= s1_last;
         s2_re_sq  <= re_ext * re_ext;
         s2_im_sq  <= im_ext * im_ext;
         out_valid <= s2_valid;
         out_last  <= s2_last;
         out_power <= POWER_WIDTH'($unsigned(s2_re_sq)) + POWER_WIDTH'($unsigned(s2_im_sq));
      end
   end

endmodule

// File: rtl/axis_spectrum_power.sv
// Per-bin spectral power stream with per-frame peak search and frame counting.
module axis_spectrum_power
   import vibrometer_axis_pkg::*;
#(
   parameter int AXIS_TDATA_WIDTH = AXIS_TDATA_WIDTH_DEF,
   parameter int POWER_WIDTH      = POWER_WIDTH_DEF,
   parameter int BIN_WIDTH        = BIN_WIDTH_DEF
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
   input  logic                        S_AXIS_tvalid,
   output logic                        S_AXIS_tready,
   input  logic                        S_AXIS_tlast,
   output logic [POWER_WIDTH-1:0]      M_AXIS_tdata,
   output logic                        M_AXIS_tvalid,
   input  logic                        M_AXIS_tready,
   output logic                        M_AXIS_tlast,
   output logic [POWER_WIDTH-1:0]      peak_value,
   output logic [BIN_WIDTH-1:0]        peak_bin,
   output logic                        peak_valid,
   output logic [31:0]                 frame_count
);

   logic                   ce;
   logic                   out_xfer;
   logic [BIN_WIDTH-1:0]   bin_cnt;
   logic                   frame_open;
   logic [POWER_WIDTH-1:0] trk_value;
   logic [BIN_WIDTH-1:0]   trk_bin;
   logic                   take_bin;
   logic [POWER_WIDTH-1:0] best_value;
   logic [BIN_WIDTH-1:0]   best_bin;

   assign ce            = ~M_AXIS_tvalid | M_AXIS_tready;
   assign S_AXIS_tready = ce & aresetn;
   assign out_xfer      = M_AXIS_tvalid & M_AXIS_tready;

   complex_mag_sq #(
      .DATA_WIDTH  (AXIS_TDATA_WIDTH),
      .POWER_WIDTH (POWER_WIDTH)
   ) u_mag (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .ce        (ce),
      .in_valid  (S_AXIS_tvalid & S_AXIS_tready),
      .in_data   (S_AXIS_tdata),
      .in_last   (S_AXIS_tlast),
      .out_valid (M_AXIS_tvalid),
      .out_power (M_AXIS_tdata),
      .out_last  (M_AXIS_tlast)
   );

   // frame_open rather than bin_cnt==0 marks the first bin, so a counter wrap keeps the running peak.
   always_comb begin
      take_bin   = ~frame_open | (M_AXIS_tdata > trk_value);
      best_value = trk_value;
      best_bin   = trk_bin;
      if (take_bin) begin
         best_value = M_AXIS_tdata;
         best_bin   = bin_cnt;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         bin_cnt     <= '0;
         frame_open  <= 1'b0;
         trk_value   <= '0;
         trk_bin     <= '0;
         peak_value  <= '0;
         peak_bin    <= '0;
         peak_valid  <= 1'b0;
         frame_count <= '0;
      end else begin
         peak_valid <= 1'b0;
         if (out_xfer) begin
            trk_value <= best_value;
            trk_bin   <= best_bin;
            if (M_AXIS_tlast) begin
               bin_cnt     <= '0;
               frame_open  <= 1'b0;
               peak_value  <= best_value;
               peak_bin    <= best_bin;
               peak_valid  <= 1'b1;
               frame_count <= frame_count + 32'd1;
            end else begin
               bin_cnt    <= bin_cnt + BIN_WIDTH'(1);
               frame_open <= 1'b1;
            end
         end
      end
   end

endmodule
